pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
Sequences the parameterized PLL wrapper from the free-running HSOSC clock. It holds the PLL in reset, waits for lock with a timeout and bounded retries, then requires lock to stay stable before releasing the system reset. It also detects lock loss during operation. It sits between the top-level reset and the PLL clock domain, drives the PLL's rst_n, and provides a system reset that the PLL-domain logic resynchronizes locally.

Parameters:
SYNC_STAGES, 2, flip-flop stages synchronizing pll_locked into clk (minimum 2)
PLL_RST_CYCLES, 16, clk cycles pll_rst_n is held low per PLL reset pulse
LOCK_TIMEOUT, 48000, clk cycles allowed in WAIT_LOCK before a retry (1 ms at 48 MHz)
STABLE_CYCLES, 4800, consecutive synchronized-lock cycles required before RUN
MAX_RETRIES, 3, timed-out lock attempts retried before FAIL
CNT_W, 16, width of the shared phase counter; must hold max(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES)

Ports:
clk  input  1  HSOSC-domain clock; free-running and independent of the PLL
reset_n  input  1  asynchronous active-low reset
pll_locked  input  1  raw PLL lock indicator; asynchronous to clk
relock_req  input  1  single-cycle request to restart the PLL sequence
pll_rst_n  output  1  drives the PLL wrapper's rst_n; active low
sys_rst_n  output  1  system reset for the PLL domain; deasserted only in RUN
ready  output  1  high in RUN
fail  output  1  high in FAIL
state  output  3  current state: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL
loss_count  output  8  saturating count of lock losses seen in RUN

Behaviour:
- All outputs are registered and decode from the state register.
- Reset values: state=RESET_PLL, pll_rst_n=0, sys_rst_n=0, ready=0, fail=0, loss_count=0. The counter and retry_cnt are also 0.
- lock_s is pll_locked after SYNC_STAGES flops; latency is SYNC_STAGES cycles.
- Every state entry clears the counter. In every other cycle the counter increments by 1.

State behaviour:
- RESET_PLL:
  - pll_rst_n=0.
  - When counter==PLL_RST_CYCLES-1, go to WAIT_LOCK. pll_rst_n is therefore low for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst_n=1.
  - If lock_s=1, go to STABLE.
  - Otherwise, if counter==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRIES, go to FAIL;
    - else retry_cnt+=1 and go to RESET_PLL.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK. This does not count as a retry.
  - Otherwise, if counter==STABLE_CYCLES-1, go to RUN and clear retry_cnt.
- RUN:
  - sys_rst_n=1, ready=1.
  - If lock_s=0, loss_count+=1 (saturates at 255) and go to RESET_PLL.
  - sys_rst_n falls on the same edge as the state change.
- FAIL:
  - pll_rst_n=0 (PLL parked in reset), fail=1.
  - Exits only on relock_req or reset_n.

relock_req:
- Highest priority; honoured in every state.
- Next state is RESET_PLL, counter cleared, retry_cnt cleared. loss_count is unchanged.
- If lock is lost in the same cycle as relock_req in RUN, loss_count still increments.

Boundary conditions:
- Lock asserting on the timeout cycle of WAIT_LOCK: lock wins, go to STABLE.
- Lock dropping on the final STABLE cycle: go to WAIT_LOCK, not RUN.
- relock_req while already in RESET_PLL restarts the PLL_RST_CYCLES count.
- Glitches on pll_locked shorter than one clk cycle may be missed; this is acceptable.
- reset_n asserted mid-sequence forces the reset values immediately, without waiting for a clk edge.

Test Plan:
(Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.)
1. Release reset_n, raise pll_locked 10 cycles later and hold it -> pll_rst_n low for exactly 4 cycles. state goes 0→1→2→3. ready and sys_rst_n rise exactly 8 cycles after entering STABLE. loss_count=0.
2. Hold pll_locked=0 -> three WAIT_LOCK timeouts of 20 cycles each, separated by 4-cycle pll_rst_n pulses. Then state=4, fail=1, pll_rst_n=0. Pulse relock_req -> state=0 and fail=0 on the next edge.
3. In RUN, drop pll_locked for 1 cycle -> after the 2-cycle sync, sys_rst_n=0, ready=0, loss_count=1, state=0. Repeat 300 times -> loss_count holds at 255.
4. In STABLE, drop pll_locked at stable count 5 -> state returns to 1 without a pll_rst_n pulse. retry_cnt is unchanged: a subsequent timeout budget of 2 retries remains.
5. Pulse relock_req in RUN in the same cycle lock_s falls -> state=0, loss_count increments by 1, retry_cnt=0.
6. Assert reset_n low mid-WAIT_LOCK, between clk edges -> all outputs take their reset values asynchronously. After release, the sequence restarts with a full 4-cycle PLL reset.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for lock with bounded retries,
// requires a stable lock window before releasing the PLL-domain system reset, and tracks lock loss.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 48000,
  parameter int STABLE_CYCLES  = 4800,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst_n,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] loss_count
);

  localparam logic [2:0] ST_RESET_PLL = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [CNT_W-1:0]       cnt_q;
  logic [RETRY_W-1:0]     retry_q;
  logic [RETRY_W-1:0]     retry_d;
  logic [2:0]             state_d;
  logic [7:0]             loss_d;
  logic                   cnt_clr;

  // pll_locked is asynchronous to clk; lock_s is its SYNC_STAGES-deep synchronized copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // relock_req is a one-cycle request with no acknowledge; it overrides every other transition.
  always_comb begin
    state_d = state;
    retry_d = retry_q;
    loss_d  = loss_count;
    if (state == ST_RUN && !lock_s && loss_count != 8'hFF) begin
      loss_d = loss_count + 8'd1;
    end
    if (relock_req) begin
      state_d = ST_RESET_PLL;
      retry_d = '0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_RESET_PLL;
            end
          end
        end
        ST_STABLE: begin
          // A lock drop while qualifying is not a retry; the PLL is left running.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lock_s) state_d = ST_RESET_PLL;
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: state_d = ST_RESET_PLL;
      endcase
    end
    cnt_clr = relock_req || (state_d != state);
  end

  // Outputs are registered from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RESET_PLL;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_count <= 8'd0;
      pll_rst_n  <= 1'b0;
      sys_rst_n  <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt_q      <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
      retry_q    <= retry_d;
      loss_count <= loss_d;
      pll_rst_n  <= (state_d != ST_RESET_PLL) && (state_d != ST_FAIL);
      sys_rst_n  <= (state_d == ST_RUN);
      ready      <= (state_d == ST_RUN);
      fail       <= (state_d == ST_FAIL);
    end
  end

endmodule
